// File: rtl/fp_addsub_pkg.sv
// Shared definitions for the sequential floating-point adder/subtractor:
// FSM state encoding, flag bit positions and format-derived constants.
package fp_addsub_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADDSUB,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // Exponent bias for an exp_w-bit exponent field
  function automatic longint unsigned bias_of(input int exp_w);
    return (64'd1 << (exp_w - 1)) - 64'd1;
  endfunction

  // Largest biased exponent of a finite result; anything above it overflows
  function automatic longint unsigned max_exp_of(input int exp_w);
    return (64'd1 << exp_w) - 64'd2;
  endfunction

  // Positive quiet NaN: all-ones exponent with the fraction MSB set
  function automatic longint unsigned qnan_of(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  logic found;

  // Scan from the MSB and report how many zeros precede the first one
  always_comb begin
    count = CW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle parametrised floating-point adder/subtractor with a start/ready
// handshake, round-to-nearest-even and flush-to-zero of subnormals.
// Define FP_ADDSUB_SPECIAL_EN to decode Inf/NaN operands and overflow to Inf;
// otherwise all-ones exponents are finite and overflow saturates.
module fp_addsub_seq
  import fp_addsub_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         ready,
  output logic         busy,
  output logic [3:0]   flags
);

  localparam int SW  = MAN_W + 4;
  localparam int LZW = $clog2(SW + 1);
  localparam int XW  = EXP_W + LZW + 2;
  localparam logic [XW-1:0] MAX_EXP = XW'(max_exp_of(EXP_W));
`ifdef FP_ADDSUB_SPECIAL_EN
  localparam logic [W-1:0] QNAN = W'(qnan_of(EXP_W, MAN_W));
`endif

  state_t            state, state_next;
  logic [W-1:0]      a_r, b_r;
  logic              sign_x, sign_y, eff_sub, zero_r;
  logic [EXP_W-1:0]  exp_x;
  logic [SW-1:0]     sig_x, sig_y, norm_sig;
  logic [SW:0]       sum_r;
  logic [XW-1:0]     norm_exp;
  logic [W-1:0]      res_pend, spec_val;
  logic [3:0]        flags_pend;
  logic              spec_hit, spec_inv;

  logic              al_sign_x, al_sign_y, al_spec_hit, al_spec_inv;
  logic [EXP_W-1:0]  al_exp_x;
  logic [SW-1:0]     al_sig_x, al_sig_y, nm_sig;
  logic [W-1:0]      al_spec_val, rd_res;
  logic [LZW-1:0]    lz;
  logic [XW-1:0]     nm_exp;
  logic [3:0]        rd_flags;

  // Next-state sequencing: a fixed walk through the pipeline stages
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_ALIGN;
      S_ALIGN:  state_next = S_ADDSUB;
      S_ADDSUB: state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_DONE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Order operands by magnitude and align the smaller one with sticky collection
  always_comb begin
    logic [W-2:0]     mag_a, mag_b, mag_x, mag_y;
    logic [SW-1:0]    y_full;
    logic [EXP_W-1:0] d;
    logic             lost;
    int               d_i;
`ifdef FP_ADDSUB_SPECIAL_EN
    logic             a_nan, b_nan, a_inf, b_inf;
`endif
    mag_a = (a_r[W-2:MAN_W] == '0) ? '0 : a_r[W-2:0];
    mag_b = (b_r[W-2:MAN_W] == '0) ? '0 : b_r[W-2:0];
    if (mag_a >= mag_b) begin
      mag_x = mag_a;  mag_y = mag_b;
      al_sign_x = a_r[W-1];  al_sign_y = b_r[W-1];
    end else begin
      mag_x = mag_b;  mag_y = mag_a;
      al_sign_x = b_r[W-1];  al_sign_y = a_r[W-1];
    end
    al_exp_x = mag_x[W-2:MAN_W];
    al_sig_x = {mag_x[W-2:MAN_W] != '0, mag_x[MAN_W-1:0], 3'b000};
    y_full   = {mag_y[W-2:MAN_W] != '0, mag_y[MAN_W-1:0], 3'b000};
    d        = mag_x[W-2:MAN_W] - mag_y[W-2:MAN_W];
    d_i      = int'(d);
    lost     = 1'b0;
    for (int i = 0; i < SW; i++) begin
      if (i < d_i) lost = lost | y_full[i];
    end
    if (d_i >= SW - 1) al_sig_y = {{(SW-1){1'b0}}, |y_full};
    else               al_sig_y = (y_full >> d_i) | {{(SW-1){1'b0}}, lost};
    al_spec_hit = 1'b0;
    al_spec_inv = 1'b0;
    al_spec_val = '0;
`ifdef FP_ADDSUB_SPECIAL_EN
    a_nan = (&a_r[W-2:MAN_W]) && (a_r[MAN_W-1:0] != '0);
    b_nan = (&b_r[W-2:MAN_W]) && (b_r[MAN_W-1:0] != '0);
    a_inf = (&a_r[W-2:MAN_W]) && (a_r[MAN_W-1:0] == '0);
    b_inf = (&b_r[W-2:MAN_W]) && (b_r[MAN_W-1:0] == '0);
    if (a_nan || b_nan || (a_inf && b_inf && (a_r[W-1] != b_r[W-1]))) begin
      al_spec_hit = 1'b1;
      al_spec_inv = 1'b1;
      al_spec_val = QNAN;
    end else if (a_inf) begin
      al_spec_hit = 1'b1;
      al_spec_val = a_r;
    end else if (b_inf) begin
      al_spec_hit = 1'b1;
      al_spec_val = b_r;
    end
`endif
  end

  fp_lzc #(.WIDTH(SW)) u_lzc (
    .value(sum_r[SW-1:0]),
    .count(lz)
  );

  // Normalise: absorb a carry-out or remove leading zeros after cancellation
  always_comb begin
    if (sum_r[SW]) begin
      nm_sig = sum_r[SW:1] | {{(SW-1){1'b0}}, sum_r[0]};
      nm_exp = {{(XW-EXP_W){1'b0}}, exp_x} + XW'(1);
    end else begin
      nm_sig = sum_r[SW-1:0] << lz;
      nm_exp = {{(XW-EXP_W){1'b0}}, exp_x} - XW'(lz);
    end
  end

  // Round to nearest even, then resolve zero, underflow, overflow and specials
  always_comb begin
    logic [MAN_W:0]   mant;
    logic [MAN_W+1:0] mant_inc;
    logic             g, r, s, up;
    logic [XW-1:0]    e;
    mant     = norm_sig[SW-1:3];
    g        = norm_sig[2];
    r        = norm_sig[1];
    s        = norm_sig[0];
    up       = g & (r | s | mant[0]);
    mant_inc = {1'b0, mant} + {{(MAN_W+1){1'b0}}, up};
    e        = norm_exp + XW'(mant_inc[MAN_W+1]);
    rd_res   = {sign_x, e[EXP_W-1:0],
                mant_inc[MAN_W+1] ? {MAN_W{1'b0}} : mant_inc[MAN_W-1:0]};
    rd_flags = 4'b0000;
    rd_flags[FLG_INX] = g | r | s;
    if (zero_r) begin
      rd_res   = {sign_x & sign_y, {(W-1){1'b0}}};
      rd_flags = 4'b0000;
    end else if (e[XW-1] || e == '0) begin
      rd_res = {sign_x, {(W-1){1'b0}}};
      rd_flags[FLG_UNF] = 1'b1;
    end else if (e > MAX_EXP) begin
`ifdef FP_ADDSUB_SPECIAL_EN
      rd_res = {sign_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rd_flags[FLG_OVF] = 1'b1;
      rd_flags[FLG_INX] = 1'b1;
`else
      rd_res = {sign_x, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      rd_flags[FLG_OVF] = 1'b1;
`endif
    end
    if (spec_hit) begin
      rd_res   = spec_val;
      rd_flags = 4'b0000;
      rd_flags[FLG_INV] = spec_inv;
    end
  end

  // State register and per-stage datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_r <= '0;  b_r <= '0;
      sign_x <= 1'b0;  sign_y <= 1'b0;  eff_sub <= 1'b0;  zero_r <= 1'b0;
      exp_x <= '0;  sig_x <= '0;  sig_y <= '0;  sum_r <= '0;
      norm_sig <= '0;  norm_exp <= '0;
      res_pend <= '0;  flags_pend <= '0;
      spec_hit <= 1'b0;  spec_inv <= 1'b0;  spec_val <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (start) begin
          a_r <= a;
          b_r <= {b[W-1] ^ sub, b[W-2:0]};
        end
        S_ALIGN: begin
          sign_x <= al_sign_x;  sign_y <= al_sign_y;
          eff_sub <= al_sign_x ^ al_sign_y;
          exp_x <= al_exp_x;  sig_x <= al_sig_x;  sig_y <= al_sig_y;
          spec_hit <= al_spec_hit;  spec_inv <= al_spec_inv;  spec_val <= al_spec_val;
        end
        S_ADDSUB: sum_r <= eff_sub ? ({1'b0, sig_x} - {1'b0, sig_y})
                                   : ({1'b0, sig_x} + {1'b0, sig_y});
        S_NORM: begin
          norm_sig <= nm_sig;
          norm_exp <= nm_exp;
          zero_r   <= (sum_r == '0);
        end
        S_ROUND: begin
          res_pend   <= rd_res;
          flags_pend <= rd_flags;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs; result and flags only change when an operation completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      ready <= (state == S_DONE);
      busy  <= (state_next != S_IDLE) || (state == S_DONE);
      if (state == S_DONE) begin
        result <= res_pend;
        flags  <= flags_pend;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: directed vectors push expected results,
// monitors pop and compare whenever a DUT raises ready.
module tb_fp_addsub_seq;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [3:0]  flg;
    int          edge0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sub;
  logic [31:0] a, b, result;
  logic        ready, busy;
  logic [3:0]  flags;

  logic        start_h, sub_h;
  logic [15:0] a_h, b_h, result_h;
  logic        ready_h, busy_h;
  logic [3:0]  flags_h;

  exp_t sq[$];
  exp_t hq[$];
  int   cyc = 0;
  int   busy_len = 0;
  int   checks = 0;
  int   errors = 0;

  fp_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .result(result), .ready(ready), .busy(busy), .flags(flags)
  );

  fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .start(start_h), .sub(sub_h), .a(a_h), .b(b_h),
    .result(result_h), .ready(ready_h), .busy(busy_h), .flags(flags_h)
  );

  // Free-running clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Main-DUT monitor: compares completions against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) busy_len = 0;
    else begin
      if (ready) begin
        if (sq.size() == 0) checkOutput("stray_ready", 64'(ready), 64'd0);
        else begin
          e = sq.pop_front();
          checkOutput($sformatf("result_op%0d", e.id), 64'(result), 64'(e.res));
          checkOutput($sformatf("flags_op%0d", e.id), 64'(flags), 64'(e.flg));
          checkOutput($sformatf("latency_op%0d", e.id), 64'(cyc - e.edge0), 64'd5);
        end
      end
      if (busy) busy_len++;
      else if (busy_len != 0) begin
        checkOutput("busy_span", 64'(busy_len), 64'd6);
        busy_len = 0;
      end
    end
  end

  // Half-precision DUT monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ready_h) begin
      if (hq.size() == 0) checkOutput("stray_ready_h", 64'(ready_h), 64'd0);
      else begin
        e = hq.pop_front();
        checkOutput($sformatf("result_h_op%0d", e.id), 64'(result_h), 64'(e.res[15:0]));
        checkOutput($sformatf("flags_h_op%0d", e.id), 64'(flags_h), 64'(e.flg));
        checkOutput($sformatf("latency_h_op%0d", e.id), 64'(cyc - e.edge0), 64'd5);
      end
    end
  end

  task automatic applyStimulus(input int id, input logic [31:0] av, input logic [31:0] bv,
                               input logic sv, input logic [31:0] er, input logic [3:0] ef,
                               input logic mid_pulse);
    exp_t e;
    @(negedge clk);
    a = av;  b = bv;  sub = sv;  start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.id = id;  e.res = er;  e.flg = ef;  e.edge0 = cyc;
    sq.push_back(e);
    if (mid_pulse) begin
      @(negedge clk);
      a = 32'hDEADBEEF;  b = 32'h12345678;  sub = ~sv;  start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < 20 && (sq.size() != 0 || busy); i++) @(negedge clk);
    checkOutput($sformatf("done_op%0d", id), 64'(sq.size() == 0 && !busy), 64'd1);
    sq.delete();
  endtask

  task automatic applyHalf(input int id, input logic [15:0] av, input logic [15:0] bv,
                           input logic sv, input logic [15:0] er, input logic [3:0] ef);
    exp_t e;
    @(negedge clk);
    a_h = av;  b_h = bv;  sub_h = sv;  start_h = 1'b1;
    @(posedge clk);
    #1;
    start_h = 1'b0;
    e.id = id;  e.res = {16'h0, er};  e.flg = ef;  e.edge0 = cyc;
    hq.push_back(e);
    for (int i = 0; i < 20 && (hq.size() != 0 || busy_h); i++) @(negedge clk);
    checkOutput($sformatf("done_h_op%0d", id), 64'(hq.size() == 0 && !busy_h), 64'd1);
    hq.delete();
  endtask

  // Global time bound
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    rst_n = 1'b0;  start = 1'b0;  sub = 1'b0;  a = '0;  b = '0;
    start_h = 1'b0;  sub_h = 1'b0;  a_h = '0;  b_h = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_flags", 64'(flags), 64'd0);
    checkOutput("reset_ready", 64'(ready), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_result_h", 64'(result_h), 64'd0);
    checkOutput("reset_busy_h", 64'(busy_h), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(1, 32'h4892342E, 32'h497116C3, 1'b0, 32'h499D186D, 4'b0000, 1'b1);
    applyStimulus(2, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 1'b0);
    applyStimulus(3, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1'b0);
    applyStimulus(4, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 1'b0);
    applyStimulus(5, 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001, 1'b0);
    applyStimulus(6, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 1'b0);
    applyStimulus(7, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1'b0);
    applyStimulus(8, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0010, 1'b0);
    applyStimulus(9, 32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 1'b0);
`ifdef FP_ADDSUB_SPECIAL_EN
    applyStimulus(10, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1'b0);
    applyStimulus(11, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 1'b0);
`else
    applyStimulus(10, 32'h7F800000, 32'h7F800000, 1'b1, 32'h00000000, 4'b0000, 1'b0);
    applyStimulus(11, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 4'b0100, 1'b0);
`endif

    // Abort an operation in ADDSUB after a start pulse arrives while busy
    @(negedge clk);
    a = 32'h3F800000;  b = 32'h40000000;  sub = 1'b0;  start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;  a = 32'h40400000;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_result", 64'(result), 64'd0);
    checkOutput("abort_flags", 64'(flags), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_ready", 64'(ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("abort_no_ready_result", 64'(result), 64'd0);
    applyStimulus(12, 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 1'b0);

    applyHalf(1, 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
    applyHalf(2, 16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000);

    repeat (3) @(negedge clk);
    checkOutput("pending_ops", 64'(sq.size() + hq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
